// File: rtl/mac_q4_12_dot_if.sv
// Operand/result bundle for the serial Q4.12 dot-product MAC.
// The master drives operands and start; the slave (the MAC) returns handshake and result.
interface mac_q4_12_dot_if;
    logic        start;
    logic [31:0] bias_q8_24;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_q4_12;
    logic [15:0] b_q4_12;
    logic [31:0] acc_q8_24;
    logic        out_valid;
    logic        busy;

    modport master (
        output start, bias_q8_24, in_valid, a_q4_12, b_q4_12,
        input  in_ready, acc_q8_24, out_valid, busy
    );

    modport slave (
        input  start, bias_q8_24, in_valid, a_q4_12, b_q4_12,
        output in_ready, acc_q8_24, out_valid, busy
    );
endinterface

// File: rtl/mac_q4_12_dot.sv
// Serial multiply-accumulate for one LSTM gate: bias + sum(a[i]*b[i]) over VEC_LEN Q4.12 pairs,
// accumulated at full width and saturated to a Q8.24 result with a one-cycle valid strobe.
module mac_q4_12_dot #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 40
) (
    input logic             clk,
    input logic             rst_n,
    mac_q4_12_dot_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic signed [ACC_W-1:0] MAX_POS = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [ACC_W-1:0] MIN_NEG = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [31:0]      prod_q, prod_d;
    logic                    prod_vld_q, prod_vld_d;
    logic [31:0]             result_q, result_d;
    logic                    accept;

    assign accept        = bus.in_valid && (state_q == ACCUM);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.acc_q8_24 = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            result_q   <= result_d;
        end
    end

    // DRAIN is left only once the product register is empty, so the clamp sees the final sum.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_vld_d = accept;
        result_d   = result_q;

        if (prod_vld_q) begin
            acc_d = acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
        end
        if (accept) begin
            prod_d = $signed(bus.a_q4_12) * $signed(bus.b_q4_12);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = {{(ACC_W-32){bus.bias_q8_24[31]}}, bus.bias_q8_24};
                    count_d = '0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(VEC_LEN - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!prod_vld_q) begin
                    state_d = OUT;
                    if (acc_q > MAX_POS) begin
                        result_d = 32'h7FFF_FFFF;
                    end else if (acc_q < MIN_NEG) begin
                        result_d = 32'h8000_0000;
                    end else begin
                        result_d = acc_q[31:0];
                    end
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mac_q4_12_dot.sv
// Randomized self-checking bench for mac_q4_12_dot (VEC_LEN=4) against a plain-arithmetic dot-product model.
module tb_mac_q4_12_dot;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   totalChecks = 0;
    int   badChecks   = 0;
    int   ovCount     = 0;
    logic [31:0] prevResult = '0;
    logic [15:0] opA [N];
    logic [15:0] opB [N];

    mac_q4_12_dot_if bus ();

    mac_q4_12_dot #(.VEC_LEN(N), .ACC_W(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.out_valid) ovCount++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product plus bias, then saturate to 32 bits.
    function automatic logic [31:0] refDot(input logic [31:0] bias);
        longint s;
        s = longint'($signed(bias));
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(opA[i])) * longint'($signed(opB[i]));
        end
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    function automatic logic [15:0] rnd16();
        logic [31:0] r;
        r = $urandom;
        return r[15:0];
    endfunction

    // Called #1 after a clock edge with the DUT idle; returns #1 after the edge that leaves OUT.
    task automatic applyStimulus(input logic [31:0] bias, input bit noisy);
        logic [31:0] expected;
        int k;
        int pulsesBefore;
        expected     = refDot(bias);
        pulsesBefore = ovCount;
        bus.start      = 1'b1;
        bus.bias_q8_24 = bias;
        if (noisy) begin
            bus.in_valid = 1'b1;
            bus.a_q4_12  = rnd16();
            bus.b_q4_12  = rnd16();
        end
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.bias_q8_24 = $urandom;
        checkOutput("in_ready_after_start", 64'(bus.in_ready), 64'd1);
        checkOutput("busy_running", 64'(bus.busy), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (noisy) begin
                repeat ($urandom_range(1, 3)) begin
                    bus.start    = 1'($urandom_range(0, 1));
                    bus.in_valid = 1'b0;
                    bus.a_q4_12  = rnd16();
                    @(posedge clk); #1;
                end
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.a_q4_12  = opA[i];
            bus.b_q4_12  = opB[i];
            @(posedge clk); #1;
        end
        bus.in_valid = noisy;
        bus.a_q4_12  = rnd16();
        bus.b_q4_12  = rnd16();
        checkOutput("in_ready_drain", 64'(bus.in_ready), 64'd0);
        k = 0;
        while (!bus.out_valid && k < 8) begin
            @(posedge clk); #1;
            k++;
            if (!bus.out_valid) checkOutput("acc_held", 64'(bus.acc_q8_24), 64'(prevResult));
        end
        checkOutput("latency", 64'(k), 64'd2);
        checkOutput("result", 64'(bus.acc_q8_24), 64'(expected));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("out_valid_pulse", 64'(bus.out_valid), 64'd0);
        checkOutput("busy_after", 64'(bus.busy), 64'd0);
        checkOutput("result_held", 64'(bus.acc_q8_24), 64'(expected));
        checkOutput("pulse_count", 64'(ovCount - pulsesBefore), 64'd1);
        prevResult = expected;
    endtask

    task automatic fillPairs(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < N; i++) begin
            opA[i] = a;
            opB[i] = b;
        end
    endtask

    initial begin
        int pulsesBefore;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.bias_q8_24 = '0;
        bus.in_valid   = 1'b0;
        bus.a_q4_12    = '0;
        bus.b_q4_12    = '0;
        #3;
        checkOutput("reset_acc", 64'(bus.acc_q8_24), 64'd0);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        #7 rst_n = 1'b1;
        @(posedge clk); #1;

        fillPairs(16'h1000, 16'h1000);
        checkOutput("basic_model", 64'(refDot(32'h0)), 64'h0400_0000);
        applyStimulus(32'h0000_0000, 1'b0);
        fillPairs(16'h1000, 16'hF000);
        applyStimulus(32'h0100_0000, 1'b0);
        checkOutput("signed_bias_value", 64'(bus.acc_q8_24), 64'hFD00_0000);
        fillPairs(16'h8000, 16'h8000);
        applyStimulus(32'h0000_0000, 1'b0);
        checkOutput("pos_clamp_value", 64'(bus.acc_q8_24), 64'h7FFF_FFFF);
        fillPairs(16'h8000, 16'h7FFF);
        applyStimulus(32'h8000_0000, 1'b0);
        checkOutput("neg_clamp_value", 64'(bus.acc_q8_24), 64'h8000_0000);
        fillPairs(16'h1000, 16'h1000);
        applyStimulus(32'h0000_0000, 1'b1);
        checkOutput("stall_value", 64'(bus.acc_q8_24), 64'h0400_0000);

        // Abort a run after two accepts with an asynchronous reset.
        pulsesBefore   = ovCount;
        bus.start      = 1'b1;
        bus.bias_q8_24 = 32'h0300_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.a_q4_12  = 16'h2000;
            bus.b_q4_12  = 16'h2000;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_acc", 64'(bus.acc_q8_24), 64'd0);
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_no_pulse", 64'(ovCount - pulsesBefore), 64'd0);
        prevResult = '0;
        for (int i = 0; i < N; i++) begin
            opA[i] = 16'h0800 + 16'(i);
            opB[i] = 16'hF800 - 16'(i);
        end
        applyStimulus(32'h0040_0000, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                opA[i] = rnd16();
                opB[i] = rnd16();
            end
            applyStimulus($urandom, 1'(r % 2));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
